// File: rtl/mem_line_adapter_pkg.sv
// Shared types and constants for the 128-bit line to 32-bit SRAM adapter.
// Beat ordering depends on MEM_LINE_ADAPTER_CRITWORD_EN (see mem_line_adapter).
package mem_line_adapter_pkg;

    localparam int MEM_LINE_BITS  = 128;
    localparam int SRAM_WORD_BITS = 32;
    localparam int MEM_BEATS      = 4;
    localparam int SRAM_RD_LAT    = 1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RESP
    } state_t;

    // A write ends on its last beat; a read also waits out the SRAM latency.
    localparam logic [2:0] WR_LAST_CNT = 3'(MEM_BEATS - 1);
    localparam logic [2:0] RD_LAST_CNT = 3'(MEM_BEATS + SRAM_RD_LAT - 1);

    function automatic logic [1:0] beat_index(input logic [1:0] cnt, input logic [1:0] first);
        return cnt + first;
    endfunction

endpackage

// File: rtl/mem_line_adapter.sv
// Splits 128-bit line reads/writes into four 32-bit SRAM beats.
// Define MEM_LINE_ADAPTER_CRITWORD_EN to start each burst at the addressed word.
module mem_line_adapter
    import mem_line_adapter_pkg::*;
(
    input  logic          mclk,
    input  logic          rst,
    input  logic          mem_en,
    input  logic          mem_we,
    input  logic          mem_re,
    input  logic [31:0]   mem_addr_sel,
    inout  logic [127:0]  mem_dat,
    output logic          mem_busy,
    output logic          mem_rd_vld,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [29:0]   sram_addr,
    output logic [31:0]   sram_wdat,
    input  logic [31:0]   sram_rdat
);

    state_t                     state, state_nxt;
    logic [2:0]                 cnt, cnt_nxt;
    logic [27:0]                line;
    logic [MEM_LINE_BITS-1:0]   line_buf;
    logic [1:0]                 first;
    logic                       rd_pend;
    logic [1:0]                 rd_idx;
    logic                       accept;
    logic                       beat_act;
    logic [1:0]                 beat_idx;
    logic                       unused_low_addr;

    assign unused_low_addr = ^mem_addr_sel[3:0];

    assign accept = (state == IDLE) && mem_en && (mem_we || mem_re) && !rst;

`ifdef MEM_LINE_ADAPTER_CRITWORD_EN
    always_ff @(posedge mclk) begin
        if (rst)
            first <= 2'b00;
        else if (accept)
            first <= mem_addr_sel[3:2];
    end
`else
    assign first = 2'b00;
`endif

    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are gated by rst so the SRAM port and bus go quiet during reset.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = 3'd0;
        beat_act   = 1'b0;
        beat_idx   = beat_index(cnt[1:0], first);
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = 30'd0;
        sram_wdat  = 32'd0;
        mem_busy   = (state != IDLE) && !rst;
        mem_rd_vld = (state == RESP) && !rst;

        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = mem_we ? WR : RD;
            end
            WR: begin
                beat_act = 1'b1;
                cnt_nxt  = cnt + 3'd1;
                if (cnt == WR_LAST_CNT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end
            end
            RD: begin
                beat_act = (cnt < 3'(MEM_BEATS));
                cnt_nxt  = cnt + 3'd1;
                if (cnt == RD_LAST_CNT) begin
                    state_nxt = RESP;
                    cnt_nxt   = 3'd0;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (beat_act && !rst) begin
            sram_cs   = 1'b1;
            sram_we   = (state == WR);
            sram_addr = {line, beat_idx};
            if (state == WR)
                sram_wdat = line_buf[{beat_idx, 5'd0} +: SRAM_WORD_BITS];
        end
    end

    // A read word arrives one cycle after its beat, so its index is delayed too.
    always_ff @(posedge mclk) begin
        if (rst) begin
            line     <= 28'd0;
            line_buf <= '0;
            rd_pend  <= 1'b0;
            rd_idx   <= 2'd0;
        end else begin
            rd_pend <= sram_cs && !sram_we;
            rd_idx  <= beat_idx;
            if (accept) begin
                line <= mem_addr_sel[31:4];
                if (mem_we)
                    line_buf <= mem_dat;
            end
            if (rd_pend)
                line_buf[{rd_idx, 5'd0} +: SRAM_WORD_BITS] <= sram_rdat;
        end
    end

    assign mem_dat = mem_rd_vld ? line_buf : 'z;

endmodule

// File: tb/tb_mem_line_adapter.sv
// Directed bench for mem_line_adapter with a one-cycle-latency SRAM model.
// The bench holds a pattern on mem_dat whenever the adapter must not drive it.
module tb_mem_line_adapter;

    logic          mclk = 1'b0;
    logic          rst;
    logic          mem_en;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   mem_addr_sel;
    wire  [127:0]  mem_dat;
    logic          mem_busy;
    logic          mem_rd_vld;
    logic          sram_cs;
    logic          sram_we;
    logic [29:0]   sram_addr;
    logic [31:0]   sram_wdat;
    logic [31:0]   sram_rdat;

    logic          tb_drv;
    logic [127:0]  tb_dat;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] LINE_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] LINE_B = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] PAT    = 128'h55555555_55555555_55555555_55555555;

`ifdef MEM_LINE_ADAPTER_CRITWORD_EN
    localparam logic [1:0] CRIT_FIRST = 2'd2;
`else
    localparam logic [1:0] CRIT_FIRST = 2'd0;
`endif

    logic [31:0] sram_model [0:255];

    assign mem_dat = tb_drv ? tb_dat : 'z;

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (sram_cs && sram_we)
            sram_model[sram_addr[7:0]] <= sram_wdat;
        sram_rdat <= sram_model[sram_addr[7:0]];
    end

    mem_line_adapter dut (
        .mclk         (mclk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_addr_sel (mem_addr_sel),
        .mem_dat      (mem_dat),
        .mem_busy     (mem_busy),
        .mem_rd_vld   (mem_rd_vld),
        .sram_cs      (sram_cs),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdat    (sram_wdat),
        .sram_rdat    (sram_rdat)
    );

    // Drive one cycle's inputs just after the edge, then wait to the sampling point.
    task automatic applyStimulus(input logic r, input logic en, input logic we, input logic re,
                                 input logic [31:0] addr, input logic drv, input logic [127:0] dat);
        @(posedge mclk);
        #1;
        rst          = r;
        mem_en       = en;
        mem_we       = we;
        mem_re       = re;
        mem_addr_sel = addr;
        tb_drv       = drv;
        tb_dat       = dat;
        @(negedge mclk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, PAT);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkSram(input string tag, input logic cs, input logic we,
                             input logic [29:0] addr, input logic [31:0] wdat);
        checkOutput({tag, "_cs"},   128'(sram_cs),   128'(cs));
        checkOutput({tag, "_we"},   128'(sram_we),   128'(we));
        checkOutput({tag, "_addr"}, 128'(sram_addr), 128'(addr));
        checkOutput({tag, "_wdat"}, 128'(sram_wdat), 128'(wdat));
    endtask

    task automatic checkStatus(input string tag, input logic busy, input logic rd_vld);
        checkOutput({tag, "_busy"},   128'(mem_busy),   128'(busy));
        checkOutput({tag, "_rd_vld"}, 128'(mem_rd_vld), 128'(rd_vld));
    endtask

    task automatic runRead(input string tag, input logic [31:0] addr, input logic [29:0] base,
                           input logic [1:0] first, input logic [127:0] exp_line);
        logic [1:0] idx;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, addr, 1'b1, PAT);
        checkStatus({tag, "_c0"}, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idleCycle();
            idx = first + 2'(k);
            checkSram($sformatf("%s_beat%0d", tag, k), 1'b1, 1'b0, base | 30'(idx), 32'd0);
            checkStatus($sformatf("%s_c%0d", tag, k + 1), 1'b1, 1'b0);
            checkOutput($sformatf("%s_c%0d_dat", tag, k + 1), mem_dat, PAT);
        end
        idleCycle();
        checkSram({tag, "_c5"}, 1'b0, 1'b0, 30'd0, 32'd0);
        checkStatus({tag, "_c5"}, 1'b1, 1'b0);
        checkOutput({tag, "_c5_dat"}, mem_dat, PAT);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, PAT);
        checkStatus({tag, "_c6"}, 1'b1, 1'b1);
        checkOutput({tag, "_c6_dat"}, mem_dat, exp_line);
        idleCycle();
        checkStatus({tag, "_c7"}, 1'b0, 1'b0);
        checkOutput({tag, "_c7_dat"}, mem_dat, PAT);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] exp_line;

        for (int i = 0; i < 256; i++)
            sram_model[i] = 32'd0;
        rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
        mem_addr_sel = 32'd0; tb_drv = 1'b1; tb_dat = PAT;

        // Reset, including a write request presented while rst is high.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, PAT);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, LINE_B);
        checkStatus("reset", 1'b0, 1'b0);
        checkSram("reset", 1'b0, 1'b0, 30'd0, 32'd0);
        checkOutput("reset_dat", mem_dat, LINE_B);
        idleCycle();
        checkStatus("rst_req_dropped", 1'b0, 1'b0);
        checkSram("rst_req_dropped", 1'b0, 1'b0, 30'd0, 32'd0);

        // Write LINE_A to 0x100.
        exp_line = LINE_A;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, LINE_A);
        checkStatus("wr_c0", 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idleCycle();
            checkSram($sformatf("wr_beat%0d", k), 1'b1, 1'b1, 30'h40 + 30'(k), exp_line[32*k +: 32]);
            checkStatus($sformatf("wr_c%0d", k + 1), 1'b1, 1'b0);
        end
        idleCycle();
        checkSram("wr_c5", 1'b0, 1'b0, 30'd0, 32'd0);
        checkStatus("wr_c5", 1'b0, 1'b0);

        // Read it back.
        runRead("rd100", 32'h100, 30'h40, 2'd0, LINE_A);

        // A write arriving while the read is busy must be dropped.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, PAT);
        for (int c = 1; c <= 6; c++) begin
            if (c == 3)
                applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, LINE_B);
            else if (c == 6)
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, PAT);
            else
                idleCycle();
            checkOutput($sformatf("drop_c%0d_we", c), 128'(sram_we), 128'(1'b0));
            checkOutput($sformatf("drop_c%0d_busy", c), 128'(mem_busy), 128'(1'b1));
        end
        checkOutput("drop_c6_dat", mem_dat, LINE_A);
        idleCycle();
        checkStatus("drop_c7", 1'b0, 1'b0);
        checkSram("drop_c7", 1'b0, 1'b0, 30'd0, 32'd0);

        // Reset in cycle 2 of a read, with a request presented alongside it.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, PAT);
        idleCycle();
        checkOutput("rstrd_c1_cs", 128'(sram_cs), 128'(1'b1));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 1'b1, LINE_B);
        for (int c = 3; c <= 7; c++) begin
            idleCycle();
            checkSram($sformatf("rstrd_c%0d", c), 1'b0, 1'b0, 30'd0, 32'd0);
            checkStatus($sformatf("rstrd_c%0d", c), 1'b0, 1'b0);
            checkOutput($sformatf("rstrd_c%0d_dat", c), mem_dat, PAT);
        end

        // we and re together behave as a write.
        exp_line = LINE_B;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, LINE_B);
        for (int k = 0; k < 4; k++) begin
            idleCycle();
            checkSram($sformatf("rw_beat%0d", k), 1'b1, 1'b1, 30'h80 + 30'(k), exp_line[32*k +: 32]);
            checkStatus($sformatf("rw_c%0d", k + 1), 1'b1, 1'b0);
        end
        for (int c = 5; c <= 7; c++) begin
            idleCycle();
            checkStatus($sformatf("rw_c%0d", c), 1'b0, 1'b0);
            checkOutput($sformatf("rw_c%0d_cs", c), 128'(sram_cs), 128'(1'b0));
        end
        runRead("rd200", 32'h200, 30'h80, 2'd0, LINE_B);

        // Read from word 2 of line 0x10; order depends on the critical-word build.
        runRead("rd108", 32'h108, 30'h40, CRIT_FIRST, LINE_A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_line_adapter.md
MEM_LINE_ADAPTER -- requirements
Module: mem_line_adapter

Interface
REQ-001 SHALL have port mclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port mem_en, input, 1 bit: request strobe from the memory interface.
REQ-004 SHALL have port mem_we, input, 1 bit: write request qualifier.
REQ-005 SHALL have port mem_re, input, 1 bit: read request qualifier.
REQ-006 SHALL have port mem_addr_sel, input, 32 bits: byte address; bits [31:4] select the 128-bit line.
REQ-007 SHALL have port mem_dat, inout, 128 bits: write line in; read line out.
REQ-008 SHALL have port mem_busy, output, 1 bit: adapter occupied; requests are not accepted.
REQ-009 SHALL have port mem_rd_vld, output, 1 bit: read line is being driven on mem_dat this cycle.
REQ-010 SHALL have port sram_cs, output, 1 bit: SRAM chip select.
REQ-011 SHALL have port sram_we, output, 1 bit: SRAM write enable.
REQ-012 SHALL have port sram_addr, output, 30 bits: SRAM word address, {line[27:0], beat[1:0]}.
REQ-013 SHALL have port sram_wdat, output, 32 bits: SRAM write word.
REQ-014 SHALL have port sram_rdat, input, 32 bits: SRAM read word, valid one cycle after a read beat.

Function
REQ-015 SHALL use FSM states IDLE, WR, RD, RESP.
REQ-016 SHALL accept a request at the edge where state==IDLE and mem_en==1 and (mem_we|mem_re)==1.
REQ-017 SHALL latch mem_addr_sel[31:4] on acceptance; on a write, SHALL also latch mem_dat into the 128-bit line buffer.
REQ-018 SHALL treat a request with mem_we&mem_re as a write; SHALL ignore mem_en without we/re.
REQ-019 SHALL ignore (drop) any request presented while mem_busy==1.
REQ-020 WR: SHALL issue 4 beats in cycles 1-4 after acceptance with sram_cs=sram_we=1 and sram_wdat=buf[32k+31:32k] for beat k, then return to IDLE.
REQ-021 RD: SHALL issue 4 read beats in cycles 1-4 with sram_cs=1 and sram_we=0, and SHALL capture sram_rdat into buf[32k+31:32k] in the following cycle (cycles 2-5).
REQ-022 RESP (cycle 6): SHALL drive mem_dat=buf and mem_rd_vld=1 for exactly one cycle, then go to IDLE.
REQ-023 SHALL drive mem_dat to high-Z in every state except RESP.
REQ-024 SHALL hold mem_busy high in cycles 1-4 for a write and 1-6 for a read, and low in IDLE; back-to-back acceptance is possible in cycle 5 (write) or 7 (read).
REQ-025 SHALL drive sram_cs=sram_we=0 and sram_wdat=0 in any cycle without a beat.

Reset
REQ-026 SHALL, while rst is high, go to IDLE and force mem_busy=0, mem_rd_vld=0, sram_cs=0, sram_we=0, sram_addr=0, sram_wdat=0, buffer=0, and mem_dat to Z.
REQ-027 SHALL abandon an in-flight operation on reset, with no response and no further beats.
REQ-028 SHALL ignore a request sampled in the same cycle as rst.

Configuration
REQ-029 With MEM_LINE_ADAPTER_CRITWORD_EN defined, beats SHALL be issued in order addr[3:2], addr[3:2]+1, ... modulo 4; without it, beats SHALL be issued in order 0,1,2,3.
REQ-030 Beat timing and final buffer contents SHALL be identical with and without MEM_LINE_ADAPTER_CRITWORD_EN.

Structure
REQ-031 Shared package/header SHALL hold the FSM state typedef and constants MEM_LINE_BITS=128, SRAM_WORD_BITS=32, MEM_BEATS=4, SRAM_RD_LAT=1.
REQ-032 SHALL be a single module with no sub-module; the beat counter and line buffer are inline.

Verification
REQ-033 Write test: write line 0x0F0E..00 to addr 0x100 -> sram_addr 0x40..0x43 carry words 0x03020100..0x0F0E0D0C in cycles 1-4; mem_busy is high for cycles 1-4.
REQ-034 Read test: read addr 0x100 after REQ-033 -> mem_rd_vld=1 in cycle 6 with mem_dat=0x0F0E..00; mem_dat is Z in all other cycles.
REQ-035 Busy-drop test: a read at cycle 0 and a write at cycle 3 -> the write is dropped, with no sram_we in cycles 1-6.
REQ-036 Reset test: assert rst in cycle 2 of a read -> sram_cs=0 from cycle 3, no mem_rd_vld, mem_busy=0.
REQ-037 Read-over-write test: mem_we=mem_re=1 -> write beats only, with no mem_rd_vld.
REQ-038 CRITWORD test (macro defined): read addr 0x108 -> beat order is sram_addr 0x42,0x43,0x40,0x41, and mem_dat is identical to REQ-034.
